// File: rtl/qfive_pkg.sv
// qfive_pkg: shared definitions for the four-state Mealy link (encoder and decoder).
//   - STATE_W       : width of the state code
//   - S1..S4        : legal state codes; every other 3-bit code is illegal
//   - next_state()  : transition function on the plain input bit a
//   - is_legal()    : true for the four legal state codes
//   - decode_bit()  : recovers a from the received z in a given state
package qfive_pkg;

  localparam int STATE_W = 3;

  localparam logic [2:0] S1 = 3'b001;
  localparam logic [2:0] S2 = 3'b010;
  localparam logic [2:0] S3 = 3'b011;
  localparam logic [2:0] S4 = 3'b100;

  // Both link ends must use this one function so they cannot drift apart.
  function automatic logic [2:0] next_state(input logic [2:0] state, input logic a);
    logic [2:0] nxt;
    nxt = S1;
    case (state)
      S1:      nxt = a ? S2 : S3;
      S2:      nxt = a ? S4 : S3;
      S3:      nxt = a ? S1 : S4;
      S4:      nxt = a ? S1 : S4;
      default: nxt = S1;
    endcase
    return nxt;
  endfunction

  function automatic logic is_legal(input logic [2:0] state);
    logic ok;
    ok = 1'b0;
    case (state)
      S1, S2, S3, S4: ok = 1'b1;
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // The encoder emits z = ~a only while in S2; elsewhere z = a.
  function automatic logic decode_bit(input logic [2:0] state, input logic z);
    logic a;
    if (state == S2) begin
      a = ~z;
    end else begin
      a = z;
    end
    return a;
  endfunction

endpackage

// File: rtl/qfive_if.sv
// qfive_if: link-side bundle for the qfive decoder.
//   master : drives z_in / z_valid / resync, observes the decoder results
//   slave  : the decoder; consumes the link inputs, drives a_out, a_valid,
//            word_out, word_valid, state_out and err
interface qfive_if #(parameter int W = 8);
  import qfive_pkg::*;

  logic               z_in;
  logic               z_valid;
  logic               resync;
  logic               a_out;
  logic               a_valid;
  logic [W-1:0]       word_out;
  logic               word_valid;
  logic [STATE_W-1:0] state_out;
  logic               err;

  modport master (
    output z_in, z_valid, resync,
    input  a_out, a_valid, word_out, word_valid, state_out, err
  );

  modport slave (
    input  z_in, z_valid, resync,
    output a_out, a_valid, word_out, word_valid, state_out, err
  );
endinterface

// File: rtl/qfive_word_packer.sv
// qfive_word_packer: collects recovered bits LSB-first into W-bit words.
//   clk, rst   : clock, synchronous active-low reset
//   clear      : drop the partial word (count and shift register to 0)
//   bit_valid  : bit_in is a recovered bit to store this cycle
//   bit_in     : recovered bit
//   word_out   : last completed word, held between pulses
//   word_valid : one-cycle pulse when word_out is updated
module qfive_word_packer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         bit_valid,
  input  logic         bit_in,
  output logic [W-1:0] word_out,
  output logic         word_valid
);
  localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  logic [CNT_W-1:0] count_r;
  logic [W-1:0]     shift_r;
  logic [W-1:0]     word_r;
  logic             word_valid_r;
  logic [W-1:0]     merged_s;

  // Shift register with the incoming bit already placed at position count.
  always_comb begin
    merged_s          = shift_r;
    merged_s[count_r] = bit_in;
  end

  // Bit counter, partial word and completed-word register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r      <= '0;
      shift_r      <= '0;
      word_r       <= '0;
      word_valid_r <= 1'b0;
    end else if (clear) begin
      count_r      <= '0;
      shift_r      <= '0;
      word_valid_r <= 1'b0;
    end else if (bit_valid) begin
      if (count_r == LAST) begin
        word_r       <= merged_s;
        word_valid_r <= 1'b1;
        count_r      <= '0;
        shift_r      <= '0;
      end else begin
        shift_r      <= merged_s;
        count_r      <= count_r + CNT_W'(1);
        word_valid_r <= 1'b0;
      end
    end else begin
      word_valid_r <= 1'b0;
    end
  end

  assign word_out   = word_r;
  assign word_valid = word_valid_r;

endmodule

// File: rtl/qfive_decoder.sv
// qfive_decoder: receive-side inverse of the four-state Mealy encoder.
// Tracks the encoder state from the z stream, recovers a, packs words.
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : qfive_if slave - z_in, z_valid, resync in;
//          a_out, a_valid, word_out, word_valid, state_out, err out
module qfive_decoder
  import qfive_pkg::*;
#(
  parameter int W = 8
) (
  input logic    clk,
  input logic    rst,
  qfive_if.slave bus
);
  logic [STATE_W-1:0] state_r;
  logic               a_out_r;
  logic               a_valid_r;
  logic               err_r;
  logic               legal_s;
  logic               a_s;
  logic               pack_clear_s;
  logic               pack_valid_s;

  // Recovered bit and legality of the current tracked state.
  always_comb begin
    legal_s      = is_legal(state_r);
    a_s          = decode_bit(state_r, bus.z_in);
    pack_clear_s = bus.resync | ~legal_s;
    pack_valid_s = bus.z_valid & ~bus.resync & legal_s;
  end

  // State tracker and registered bit outputs; resync beats illegal recovery.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= S1;
      a_out_r   <= 1'b0;
      a_valid_r <= 1'b0;
      err_r     <= 1'b0;
    end else if (bus.resync) begin
      state_r   <= S1;
      a_valid_r <= 1'b0;
      err_r     <= 1'b0;
    end else if (!legal_s) begin
      state_r   <= S1;
      a_valid_r <= 1'b0;
      err_r     <= 1'b1;
    end else if (bus.z_valid) begin
      state_r   <= next_state(state_r, a_s);
      a_out_r   <= a_s;
      a_valid_r <= 1'b1;
      err_r     <= 1'b0;
    end else begin
      a_valid_r <= 1'b0;
      err_r     <= 1'b0;
    end
  end

  qfive_word_packer #(.W(W)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear_s),
    .bit_valid  (pack_valid_s),
    .bit_in     (a_s),
    .word_out   (bus.word_out),
    .word_valid (bus.word_valid)
  );

  assign bus.a_out     = a_out_r;
  assign bus.a_valid   = a_valid_r;
  assign bus.state_out = state_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_qfive_decoder.sv
// tb_qfive_decoder: drives a W=4 and a W=8 decoder with identical streams and
// compares both against a table-driven reference model of the link.
module tb_qfive_decoder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  qfive_if #(.W(4)) bus4 ();
  qfive_if #(.W(8)) bus8 ();

  qfive_decoder #(.W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  qfive_decoder #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: state index 1..4 (numerically equal to its 3-bit code).
  int   nxt_a0 [5] = '{0, 3, 3, 4, 4};
  int   nxt_a1 [5] = '{0, 2, 4, 1, 1};
  int   m_state;
  bit   m_a_out, m_a_valid, m_err;
  bit   m_wv4, m_wv8;
  logic [3:0] m_w4;
  logic [7:0] m_w8;
  bit   q4 [$];
  bit   q8 [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit z, input bit v,
                                     input bit rs, input bit ill);
    bit a;
    if (!r) begin
      m_state = 1; m_a_out = 0; m_a_valid = 0; m_err = 0;
      m_wv4 = 0; m_wv8 = 0; m_w4 = '0; m_w8 = '0;
      q4.delete(); q8.delete();
    end else if (rs) begin
      m_state = 1; m_a_valid = 0; m_err = 0; m_wv4 = 0; m_wv8 = 0;
      q4.delete(); q8.delete();
    end else if (ill) begin
      m_state = 1; m_a_valid = 0; m_err = 1; m_wv4 = 0; m_wv8 = 0;
      q4.delete(); q8.delete();
    end else if (v) begin
      a = (m_state == 2) ? ~z : z;
      m_state = a ? nxt_a1[m_state] : nxt_a0[m_state];
      m_a_out = a; m_a_valid = 1; m_err = 0;
      q4.push_back(a); q8.push_back(a);
      m_wv4 = 0; m_wv8 = 0;
      if (q4.size() == 4) begin
        m_w4 = '0;
        for (int i = 0; i < 4; i++) if (q4[i]) m_w4 = m_w4 + (4'd1 << i);
        m_wv4 = 1; q4.delete();
      end
      if (q8.size() == 8) begin
        m_w8 = '0;
        for (int i = 0; i < 8; i++) if (q8[i]) m_w8 = m_w8 + (8'd1 << i);
        m_wv8 = 1; q8.delete();
      end
    end else begin
      m_a_valid = 0; m_err = 0; m_wv4 = 0; m_wv8 = 0;
    end
  endfunction

  task automatic compare_all();
    check_val("a_valid4",    32'(bus4.a_valid),    32'(m_a_valid));
    check_val("a_out4",      32'(bus4.a_out),      32'(m_a_out));
    check_val("state4",      32'(bus4.state_out),  32'(m_state));
    check_val("err4",        32'(bus4.err),        32'(m_err));
    check_val("word_valid4", 32'(bus4.word_valid), 32'(m_wv4));
    check_val("word4",       32'(bus4.word_out),   32'(m_w4));
    check_val("a_valid8",    32'(bus8.a_valid),    32'(m_a_valid));
    check_val("a_out8",      32'(bus8.a_out),      32'(m_a_out));
    check_val("state8",      32'(bus8.state_out),  32'(m_state));
    check_val("err8",        32'(bus8.err),        32'(m_err));
    check_val("word_valid8", 32'(bus8.word_valid), 32'(m_wv8));
    check_val("word8",       32'(bus8.word_out),   32'(m_w8));
  endtask

  // One clock: drive inputs, optionally upset the state, then check after the edge.
  task automatic step(input bit r, input bit z, input bit v, input bit rs, input bit ill);
    rst = r;
    bus4.z_in = z; bus4.z_valid = v; bus4.resync = rs;
    bus8.z_in = z; bus8.z_valid = v; bus8.resync = rs;
    if (ill) begin
      force dut4.state_r = 3'b111;
      force dut8.state_r = 3'b111;
      #1;
      release dut4.state_r;
      release dut8.state_r;
    end
    @(posedge clk);
    #1;
    model_step(r, z, v, rs, ill);
    compare_all();
  endtask

  initial begin
    bit seq [6];
    bit r, z, v, rs, ill;
    seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b0;
    bus4.z_in = 1'b0; bus4.z_valid = 1'b0; bus4.resync = 1'b0;
    bus8.z_in = 1'b0; bus8.z_valid = 1'b0; bus8.resync = 1'b0;

    // Reset held two cycles, then released with no valid input.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Known sequence from S1: path S2,S4,S1,S3,S4,S1; W=4 word 4'h7.
    foreach (seq[i]) step(1, seq[i], 1, 0, 0);

    // All zeros from S1: S3 then S4 forever; one 8-bit word of 0.
    step(1, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0);

    // S2 inversion: z=1,1 from S1 gives a=1 then 0.
    step(1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);

    // Gaps, then resync together with z_valid, then a fresh word.
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    for (int i = 0; i < 8; i++) step(1, i[0], 1, 0, 0);

    // Illegal state upset mid-word, then the err pulse must clear.
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 1);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0);

    // Reset mid-word drops the partial word.
    step(1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0);

    // Randomized traffic with occasional resync, upsets and resets.
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 63) != 0);
      rs  = r && ($urandom_range(0, 15) == 0);
      ill = r && !rs && ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 3) != 0);
      z   = 1'($urandom_range(0, 1));
      step(r, z, v, rs, ill);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qfive_decoder.md
Name: qfive_decoder

Overview:
- Receive-side inverse of the four-state Mealy encoder (input a, output z).
- Tracks the encoder's state from the received z stream and recovers the original a bit each valid cycle.
- Packs recovered bits into W-bit words for downstream logic.
- Sits at the far end of the encoder's z link, clocked by the same clk.

Parameters:
- W, 8, number of recovered bits per assembled word (W >= 2).

Ports:
- clk  input  1  system clock; all state changes on posedge clk.
- rst  input  1  synchronous, active-low reset (sampled on posedge clk; rst==0 resets).
- z_in  input  1  received encoder output bit.
- z_valid  input  1  z_in is valid this cycle; decoder advances only when high.
- resync  input  1  force tracker back to S1 and clear word assembly.
- a_out  output  1  recovered a bit.
- a_valid  output  1  one-cycle pulse; a_out is valid.
- word_out  output  W  assembled word, LSB = first recovered bit.
- word_valid  output  1  one-cycle pulse; word_out updated.
- state_out  output  3  current tracked state, for debug.
- err  output  1  one-cycle pulse; illegal state was detected and recovered.

Behaviour:
- State encoding (3 bits): S1=001, S2=010, S3=011, S4=100. Every other code is illegal.
- Reset (rst==0 at posedge) values:
  - state = S1, bit count = 0, shift register = 0.
  - a_out=0, a_valid=0, word_out=0, word_valid=0, err=0.
- Decode rule, applied on a cycle with z_valid=1:
  - In S2: a = ~z_in.
  - In S1, S3, S4: a = z_in.
- Next state, as a function of the recovered a:
  - S1: a=0 -> S3; a=1 -> S2.
  - S2: a=0 -> S3; a=1 -> S4.
  - S3: a=0 -> S4; a=1 -> S1.
  - S4: a=0 -> S4; a=1 -> S1.
- Latency: a_out and a_valid are registered and appear 1 cycle after the z_valid sample.
- z_valid=0: state, count and shift register hold; a_valid=0 and word_valid=0 that cycle; a_out holds its last value.
- Word assembly:
  - The recovered bit is written into shift register position count; count increments.
  - On the sample where count==W-1: word_out <= completed word (including this bit), word_valid pulses with the same 1-cycle latency as a_valid, and count wraps to 0.
  - word_out holds between pulses.
- resync=1 (priority over z_valid): state <= S1, count <= 0, shift register <= 0.
  - Any z_in sampled that cycle is discarded; a_valid=0 and word_valid=0.
  - word_out keeps its last value.
- Illegal state (e.g. after an upset):
  - state <= S1, count <= 0, err pulses 1 cycle; no a_valid that cycle.
- Priority order: rst > resync > illegal-state recovery > normal decode.
- Reset mid-word: the partial word is dropped and no word_valid is produced.
- Everything is fully synchronous; no logic depends on the level of z_in between clock edges.

Decomposition:
- Shared package qfive_pkg holds:
  - state constants S1..S4 and the 3-bit state width;
  - the transition function next_state(state, a), reused by encoder and decoder so both ends stay consistent.
- One natural sub-module: qfive_word_packer (count + shift register + word_valid generation, parameter W), instantiated by qfive_decoder.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> state_out=001, a_valid=0, word_valid=0, word_out=0, err=0.
- Known sequence, W=4, from S1: z_in=1,0,1,0,0,1 on consecutive z_valid cycles -> a_out=1,1,1,0,0,1 (each 1 cycle later); state path S2,S4,S1,S3,S4,S1; word_valid pulses once after the 4th bit with word_out=4'h7.
- All zeros: z_in=0 for 8 valid cycles, W=8 -> a_out all 0; state S3 then S4 and stays S4; word_out=8'h00 with one word_valid.
- S2 inversion: z_in=1,1 from S1 -> a_out=1 then 0; state S2 then S3.
- Gaps and resync:
  - z_valid toggled 1,0,1 -> state and count advance only on the valid cycles.
  - Then resync=1 together with z_valid=1 -> state=S1, count=0, no a_valid; next word starts at bit 0.
- Illegal state: force state to 3'b111 -> next cycle state=S1, err=1 for exactly 1 cycle, count=0.
